camera_row_buffer: RTL
======================

// Module: camera_row_buffer
// PURPOSE
//   Stage directly upstream of the frame uploader. Packs RGB565 pixels from the capture path
//   into 32-bit words held in a two-row ping-pong buffer.
//   Emits a frame/row command stream (1=frame start, 2=row ready, 3=frame end) through a small FIFO.
//   The uploader drains the FIFO with a valid/read_rdy handshake.
//   The uploader reads the ready row by word address: 1 cycle latency, 2 pixels per word.
// PARAMETERS
//   FRAME_WIDTH   640  pixels per row; even, <=2046
//   FRAME_HEIGHT  480  rows per frame
//   CMD_DEPTH     4    command FIFO entries; power of 2, >=4
// PORTS
//   clk                 in   1   single clock for all logic
//   reset               in   1   synchronous, active-high reset
//   frame_sync          in   1   1-cycle pulse at the start of a camera frame
//   pix_valid           in   1   pix_data holds a valid pixel this cycle
//   pix_data            in   16  RGB565 pixel
//   command_data_valid  out  1   FIFO not empty
//   command_data        out  2   FIFO head: 1 frame start, 2 row ready, 3 frame end
//   read_rdy            in   1   pops the FIFO head when command_data_valid=1
//   pixel_addr          in   10  word address within the current read row
//   pixel_data          out  32  {pixel[2a+1], pixel[2a]}, registered
//   overrun             out  1   sticky: a row arrived with no free bank
//   cmd_overflow        out  1   sticky: a command was dropped on a full FIFO
// BEHAVIOUR
//   Reset values:
//     - command_data_valid=0, command_data=0, pixel_data=0, overrun=0, cmd_overflow=0.
//     - FIFO empty; col/row counters 0; wr_bank=0; rd_bank=1.
//     - Both banks free; frame_active=0.
//   frame_sync:
//     - Pushes cmd 1, clears col/row counters, sets frame_active=1.
//     - Discards any partial row (no cmd 2 for it).
//     - Does not touch bank ownership or the FIFO contents.
//   Pixel packing (only when frame_active):
//     - Even column: pixel latched into the low half.
//     - Odd column: word {pix_data, low} written to bank[wr_bank][col>>1].
//   Row completion:
//     - col==FRAME_WIDTH-1 with pix_valid completes a row: col<=0, row<=row+1.
//     - Pushes cmd 2 and marks wr_bank pending; wr_bank toggles.
//   Frame completion:
//     - When the completed row is row FRAME_HEIGHT-1, also pushes cmd 3 in the next cycle.
//     - Then clears frame_active; pixels are ignored until the next frame_sync.
//   Pop / read-bank handling:
//     - Pop occurs when read_rdy && command_data_valid.
//     - Popping cmd 2 or cmd 3 releases the bank at rd_bank (row finished uploading).
//     - Popping cmd 2 additionally toggles rd_bank, selecting the newly announced row.
//     - Popping cmd 1 changes nothing.
//   Read port:
//     - pixel_data <= bank[rd_bank][pixel_addr] on every clk; data valid 1 cycle after the address.
//     - An address >= FRAME_WIDTH/2 returns an undefined value and has no side effect.
//   Overrun:
//     - Condition: the first pixel of a row (col==0) arrives while bank wr_bank is still pending.
//     - Sets overrun and suppresses buffer writes for that whole row.
//     - Counting, cmd 2 push and wr_bank toggle still occur, so the command stream stays consistent.
//     - That row's content is undefined.
//   FIFO:
//     - command_data_valid = !empty; command_data = head (combinational from the FIFO registers).
//     - Push and pop in the same cycle: both happen and occupancy is unchanged; allowed when full.
//     - Push when full without a pop: command dropped, cmd_overflow set.
//     - Same-cycle cmd 1 (frame_sync) and cmd 2 (row end): frame_sync wins; the row is discarded.
//   Counters:
//     - col is 11-bit, row is 11-bit.
//     - All address arithmetic is truncated to the declared width; no wrap inside a frame.
//   Reset mid-operation: returns to the reset state next cycle; buffer RAM contents are not cleared.
// TESTING  (FRAME_WIDTH=8, FRAME_HEIGHT=2, CMD_DEPTH=4 unless noted)
//   - frame_sync, then 16 pixels 0x0000..0x000F with read_rdy held 0:
//       -> FIFO holds 1,2,2,3; overrun=0.
//       -> After popping 1 and 2: pixel_addr=0..3 -> 0x00010000, 0x00030002, 0x00050004, 0x00070006.
//   - Continue popping the second 2: pixel_addr=1 -> 0x000B000A.
//       -> Pop 3, then check bank release: a new frame of 16 pixels runs with overrun=0.
//   - FRAME_HEIGHT=4, no pops after cmd 1 and 8 rows-worth of pixels:
//       -> Third row sets overrun=1 and its buffer writes are suppressed.
//       -> cmd 2 is still queued.
//   - CMD_DEPTH=4, FRAME_HEIGHT=4, read_rdy=0:
//       -> The fifth push (cmd 2 of row 3) sets cmd_overflow=1.
//       -> FIFO still reads 1,2,2,2 in order.
//   - frame_sync after 5 pixels of row 0:
//       -> Queue shows 1,1 with no 2.
//       -> The next 8 pixels produce a single cmd 2 with correct data.
//   - reset asserted mid-row with the FIFO non-empty:
//       -> Next cycle command_data_valid=0, overrun=0.
//       -> Pixels are ignored until frame_sync.

Source files
------------

// File: rtl/camera_row_buffer.sv
`default_nettype none
// ============================================================================
// camera_row_buffer
//   Packs RGB565 pixels into a two-row ping-pong buffer of 32-bit words and
//   queues frame start / row ready / frame end commands for the uploader.
//   Revision: 1.0
// ============================================================================
module camera_row_buffer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int CMD_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_sync,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        command_data_valid,
  output logic [1:0]  command_data,
  input  logic        read_rdy,
  input  logic [9:0]  pixel_addr,
  output logic [31:0] pixel_data,
  output logic        overrun,
  output logic        cmd_overflow
);

  localparam int WORDS = FRAME_WIDTH / 2;
  localparam int AW    = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam int PW    = $clog2(CMD_DEPTH);

  localparam logic [1:0]    CMD_FRAME_START = 2'd1;
  localparam logic [1:0]    CMD_ROW_READY   = 2'd2;
  localparam logic [1:0]    CMD_FRAME_END   = 2'd3;
  localparam logic [10:0]   LAST_COL        = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0]   LAST_ROW        = 11'(FRAME_HEIGHT - 1);
  localparam logic [PW:0]   FIFO_FULL       = (PW + 1)'(CMD_DEPTH);
  localparam logic [PW-1:0] PTR_ONE         = PW'(1);
  localparam logic [9:0]    ADDR_LIMIT      = 10'(WORDS);

  logic [31:0]   bank0 [2**AW];
  logic [31:0]   bank1 [2**AW];
  logic [1:0]    fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [10:0]   col;
  logic [10:0]   row;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    pending;
  logic          frame_active;
  logic [15:0]   low_half;
  logic          row_skip;
  logic          end_pending;

  logic          empty;
  logic          full;
  logic          pop;
  logic          accept;
  logic          row_done;
  logic          skip_now;
  logic          write_en;
  logic          push;
  logic          push_ok;
  logic [1:0]    push_cmd;
  logic          addr_ok;

  always_comb begin
    empty    = (count == '0);
    full     = (count == FIFO_FULL);
    pop      = read_rdy && !empty;
    accept   = frame_active && pix_valid && !frame_sync;
    row_done = accept && (col == LAST_COL);
    // The overrun decision is taken on the first pixel and held for the row.
    skip_now = (col == 11'd0) ? pending[wr_bank] : row_skip;
    write_en = accept && col[0] && !skip_now;
    addr_ok  = (pixel_addr < ADDR_LIMIT);
    push     = 1'b0;
    push_cmd = 2'd0;
    // A frame_sync coinciding with a row end or a pending frame end wins.
    if (frame_sync) begin
      push     = 1'b1;
      push_cmd = CMD_FRAME_START;
    end else if (end_pending) begin
      push     = 1'b1;
      push_cmd = CMD_FRAME_END;
    end else if (row_done) begin
      push     = 1'b1;
      push_cmd = CMD_ROW_READY;
    end
    push_ok            = push && (!full || pop);
    command_data_valid = !empty;
    command_data       = empty ? 2'd0 : fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!reset && write_en) begin
      if (wr_bank) begin
        bank1[col[AW:1]] <= {pix_data, low_half};
      end else begin
        bank0[col[AW:1]] <= {pix_data, low_half};
      end
    end
    if (!reset && push_ok) begin
      fifo_mem[wr_ptr] <= push_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      col          <= 11'd0;
      row          <= 11'd0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b1;
      pending      <= 2'b00;
      frame_active <= 1'b0;
      low_half     <= 16'd0;
      row_skip     <= 1'b0;
      end_pending  <= 1'b0;
      pixel_data   <= 32'd0;
      overrun      <= 1'b0;
      cmd_overflow <= 1'b0;
    end else begin
      if (addr_ok) begin
        pixel_data <= rd_bank ? bank1[pixel_addr[AW-1:0]] : bank0[pixel_addr[AW-1:0]];
      end else begin
        pixel_data <= 32'd0;
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else if (push) begin
        cmd_overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end

      // Release happens before the row-end mark so a same-bank mark wins.
      if (pop && command_data[1]) begin
        pending[rd_bank] <= 1'b0;
        if (command_data == CMD_ROW_READY) begin
          rd_bank <= ~rd_bank;
        end
      end

      if (frame_sync) begin
        col          <= 11'd0;
        row          <= 11'd0;
        frame_active <= 1'b1;
        end_pending  <= 1'b0;
        row_skip     <= 1'b0;
      end else begin
        if (end_pending) begin
          end_pending <= 1'b0;
        end
        if (accept) begin
          if (col == 11'd0) begin
            row_skip <= pending[wr_bank];
            if (pending[wr_bank]) begin
              overrun <= 1'b1;
            end
          end
          if (!col[0]) begin
            low_half <= pix_data;
          end
          if (row_done) begin
            col              <= 11'd0;
            row              <= row + 11'd1;
            pending[wr_bank] <= 1'b1;
            wr_bank          <= ~wr_bank;
            if (row == LAST_ROW) begin
              end_pending  <= 1'b1;
              frame_active <= 1'b0;
            end
          end else begin
            col <= col + 11'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
